// File: rtl/cache_port_arbiter_pkg.sv
// Shared widths and controller state type for the cache array port arbiter.
// Imported by the arbiter top and its testbench.
package cache_port_arbiter_pkg;

  localparam int CACHE_ADDR_W = 8;
  localparam int CACHE_DATA_W = 19;

  typedef enum logic {
    ARB_INIT,
    ARB_RUN
  } cache_arb_state_t;

endpackage

// File: rtl/cache_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found scanning upward from ptr, wrapping at N_RD.
module rr_arbiter #(
  parameter int N_RD = 2
) (
  input  logic [N_RD-1:0]         req,
  input  logic [$clog2(N_RD)-1:0] ptr,
  output logic [N_RD-1:0]         grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_RD; k++) begin
      idx = (int'(ptr) + k) % N_RD;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Sweeps the cache array to zero after reset, then shares its single read port
// round-robin among N_RD requesters and passes one writer to the write port.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int N_RD   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_RD-1:0]              rd_req_valid,
  input  logic [N_RD-1:0][ADDR_W-1:0]  rd_req_addr,
  output logic [N_RD-1:0]              rd_req_ready,
  output logic [N_RD-1:0]              rd_rsp_valid,
  output logic [DATA_W-1:0]            rd_rsp_data,
  input  logic                         wr_req_valid,
  input  logic [ADDR_W-1:0]            wr_req_addr,
  input  logic [DATA_W-1:0]            wr_req_data,
  output logic                         wr_req_ready,
  output logic                         init_done,
  output logic                         arr_r_en,
  output logic [ADDR_W-1:0]            arr_raddr,
  input  logic [DATA_W-1:0]            arr_dout,
  output logic                         arr_w_en,
  output logic [ADDR_W-1:0]            arr_waddr,
  output logic [DATA_W-1:0]            arr_din
);

  localparam int PTR_W = $clog2(N_RD);

  cache_arb_state_t  state, state_nxt;
  logic [ADDR_W-1:0] counter;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt, ptr_adv;
  logic [N_RD-1:0]   grant, rsp_owner;
  logic [ADDR_W-1:0] gnt_addr;
  logic              rd_hs, wr_hs, collide;
  logic              byp_valid;
  logic [DATA_W-1:0] byp_data, rsp_hold, rsp_data_now;

  rr_arbiter #(.N_RD(N_RD)) u_rr_arbiter (
    .req   (rd_req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_INIT;
      counter <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB_INIT) counter <= counter + 1'b1;
    end
  end

  always_comb begin
    gnt_addr = '0;
    ptr_adv  = rr_ptr;
    for (int i = 0; i < N_RD; i++) begin
      if (grant[i]) begin
        gnt_addr = rd_req_addr[i];
        ptr_adv  = (i == N_RD - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  assign rd_hs   = (state == ARB_RUN) && (|grant);
  assign wr_hs   = (state == ARB_RUN) && wr_req_valid;
  assign collide = rd_hs && wr_hs && (gnt_addr == wr_req_addr);

  // NOTE: every output gets a default before the case, so no path through this
  // block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    rd_req_ready = '0;
    wr_req_ready = 1'b0;
    arr_r_en     = 1'b0;
    arr_raddr    = '0;
    arr_w_en     = 1'b0;
    arr_waddr    = '0;
    arr_din      = '0;
    unique case (state)
      ARB_INIT: begin
        // NOTE: gated by rst_n so the sweep write is quiet while reset is held;
        // the first real write lands on the first edge after release.
        arr_w_en  = rst_n;
        arr_waddr = counter;
        if (counter == '1) state_nxt = ARB_RUN;
      end
      ARB_RUN: begin
        wr_req_ready = 1'b1;
        rd_req_ready = grant;
        arr_r_en     = rd_hs;
        arr_raddr    = gnt_addr;
        if (rd_hs) rr_ptr_nxt = ptr_adv;
        if (wr_hs) begin
          arr_w_en  = 1'b1;
          arr_waddr = wr_req_addr;
          arr_din   = wr_req_data;
        end
      end
      default: state_nxt = ARB_INIT;
    endcase
  end

  // Response pipeline: owner strobe and the same-cycle write bypass, since the
  // array returns the pre-write word on a read/write collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      rsp_owner <= '0;
      byp_valid <= 1'b0;
      byp_data  <= '0;
      rsp_hold  <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      rsp_owner <= rd_req_ready;
      byp_valid <= collide;
      if (collide) byp_data <= wr_req_data;
      if (|rsp_owner) rsp_hold <= rsp_data_now;
    end
  end

  assign rsp_data_now = byp_valid ? byp_data : arr_dout;
  assign rd_rsp_data  = (|rsp_owner) ? rsp_data_now : rsp_hold;
  assign rd_rsp_valid = rsp_owner;
  assign init_done    = (state == ARB_RUN);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: a behavioural array and reference
// model predict every ready and response; a monitor compares responses.
module tb_cache_port_arbiter;
  import cache_port_arbiter_pkg::*;

  localparam int ADDR_W = CACHE_ADDR_W;
  localparam int DATA_W = CACHE_DATA_W;
  localparam int N_RD   = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [N_RD-1:0]             rd_req_valid;
  logic [N_RD-1:0][ADDR_W-1:0] rd_req_addr;
  logic [N_RD-1:0]             rd_req_ready;
  logic [N_RD-1:0]             rd_rsp_valid;
  logic [DATA_W-1:0]           rd_rsp_data;
  logic                        wr_req_valid;
  logic [ADDR_W-1:0]           wr_req_addr;
  logic [DATA_W-1:0]           wr_req_data;
  logic                        wr_req_ready;
  logic                        init_done;
  logic                        arr_r_en;
  logic [ADDR_W-1:0]           arr_raddr;
  logic [DATA_W-1:0]           arr_dout;
  logic                        arr_w_en;
  logic [ADDR_W-1:0]           arr_waddr;
  logic [DATA_W-1:0]           arr_din;

  cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RD(N_RD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req_valid (rd_req_valid),
    .rd_req_addr  (rd_req_addr),
    .rd_req_ready (rd_req_ready),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_ready (wr_req_ready),
    .init_done    (init_done),
    .arr_r_en     (arr_r_en),
    .arr_raddr    (arr_raddr),
    .arr_dout     (arr_dout),
    .arr_w_en     (arr_w_en),
    .arr_waddr    (arr_waddr),
    .arr_din      (arr_din)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural read-first array, seeded with garbage so the sweep matters.
  logic [DATA_W-1:0] sram [DEPTH];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= DATA_W'($urandom);
      seeded <= 1'b1;
    end else if (arr_w_en) begin
      sram[arr_waddr] <= arr_din;
    end
    if (arr_r_en) arr_dout <= sram[arr_raddr];
  end

  typedef struct {
    int                due;
    int                owner;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: evaluated mid-cycle while inputs are stable.
  logic [DATA_W-1:0]        ref_mem [DEPTH];
  int                       sweep;
  bit                       run;
  int                       last_g;
  int                       g;
  int                       idx;
  logic [N_RD-1:0]          exp_rdy;
  logic [ADDR_W+DATA_W:0]   w_act, w_exp;
  exp_t                     m_e;

  always @(negedge clk) begin : model
    if (!rst_n) begin
      exp_q.delete();
      sweep  = 0;
      run    = 1'b0;
      last_g = N_RD - 1;
      check("reset_outputs",
            64'({rd_req_ready, wr_req_ready, init_done, arr_w_en, arr_r_en,
                 arr_waddr, arr_raddr, arr_din, rd_rsp_data}), 64'd0);
    end else if (!run) begin
      check("init_write", 64'({arr_w_en, arr_waddr, arr_din}),
            64'({1'b1, ADDR_W'(sweep), DATA_W'(0)}));
      check("init_quiet", 64'({rd_req_ready, wr_req_ready, arr_r_en, init_done}), 64'd0);
      sweep++;
      if (sweep == DEPTH) begin
        run = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end else begin
      g = -1;
      for (int k = 1; k <= N_RD; k++) begin
        idx = (last_g + k) % N_RD;
        if (g < 0 && rd_req_valid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("run_ready", 64'({rd_req_ready, wr_req_ready, init_done}), 64'({exp_rdy, 1'b1, 1'b1}));
      w_act = arr_w_en ? {1'b1, arr_waddr, arr_din} : '0;
      w_exp = wr_req_valid ? {1'b1, wr_req_addr, wr_req_data} : '0;
      check("write_port", 64'(w_act), 64'(w_exp));
      if (g >= 0) begin
        check("read_port", 64'({arr_r_en, arr_raddr}), 64'({1'b1, rd_req_addr[g]}));
        m_e.due   = cyc + 1;
        m_e.owner = g;
        m_e.data  = (wr_req_valid && wr_req_addr == rd_req_addr[g]) ? wr_req_data
                                                                   : ref_mem[rd_req_addr[g]];
        exp_q.push_back(m_e);
        last_g = g;
      end else begin
        check("read_idle", 64'(arr_r_en), 64'd0);
      end
      if (wr_req_valid) ref_mem[wr_req_addr] = wr_req_data;
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      check("rsp_in_reset", 64'(rd_rsp_valid), 64'd0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      check("rsp_owner", 64'(rd_rsp_valid), 64'(1 << mon_e.owner));
      check("rsp_data", 64'(rd_rsp_data), 64'(mon_e.data));
    end else begin
      check("rsp_idle", 64'(rd_rsp_valid), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req_valid = '0;
    wr_req_valid = 1'b0;
  endtask

  task automatic rnd_inputs(input int addr_max);
    rd_req_valid = N_RD'($urandom);
    for (int i = 0; i < N_RD; i++) rd_req_addr[i] = ADDR_W'($urandom_range(0, addr_max));
    wr_req_valid = 1'($urandom_range(0, 1));
    wr_req_addr  = ADDR_W'($urandom_range(0, addr_max));
    wr_req_data  = DATA_W'($urandom);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_req_valid = 1'b1;
    wr_req_addr  = a;
    wr_req_data  = d;
  endtask

  task automatic rd(input int r, input logic [ADDR_W-1:0] a);
    rd_req_valid[r] = 1'b1;
    rd_req_addr[r]  = a;
  endtask

  initial begin
    rst_n        = 1'b0;
    rd_req_valid = '0;
    rd_req_addr  = '0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (DEPTH) step();

    rd(0, 8'h05); step(); idle(); step();

    wr(8'h01, 19'd1); step();
    for (int i = 2; i <= 4; i++) begin
      wr(ADDR_W'(i), DATA_W'(i));
      rd(0, ADDR_W'(i - 1));
      step();
    end
    idle(); rd(0, 8'h04); step();
    idle(); repeat (2) step();

    wr(8'h10, 19'h7FFFF); rd(1, 8'h10); step();
    idle(); repeat (2) step();

    rd(0, 8'h01); rd(1, 8'h02);
    repeat (4) step();
    idle(); repeat (2) step();

    for (int n = 0; n < 1500; n++) begin
      rnd_inputs(15);
      step();
    end
    idle(); repeat (2) step();

    rd(0, 8'h03); step();
    idle(); rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      rnd_inputs(DEPTH - 1);
      step();
    end
    idle();
    rd(1, 8'h10); step();
    rd(0, 8'h01); rd(1, 8'h02); step();
    idle(); step();
    for (int n = 0; n < 200; n++) begin
      rnd_inputs(7);
      step();
    end
    idle(); repeat (3) step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Sequencing and sharing controller for the 256-entry x 19-bit simple dual-port cache array (one write port, one synchronous read port, 1-cycle read latency). After reset it sweeps the array to zero, then grants the single read port round-robin between N_RD read requesters and passes one write requester straight to the write port. It routes each read response back to its owner and forwards write data on same-cycle same-address collisions. It sits between the core's cache clients and the array macro.

## Interface
Parameters:
- ADDR_W, 8, array address width; depth = 2**ADDR_W
- DATA_W, 19, array word width
- N_RD, 2, number of read requesters (2..4)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_req_valid  in  N_RD  per-requester read request
- rd_req_addr  in  N_RD x ADDR_W  per-requester read address
- rd_req_ready  out  N_RD  request accepted this cycle
- rd_rsp_valid  out  N_RD  one-hot response strobe
- rd_rsp_data  out  DATA_W  shared response data
- wr_req_valid  in  1  write request
- wr_req_addr  in  ADDR_W  write address
- wr_req_data  in  DATA_W  write data
- wr_req_ready  out  1  write accepted this cycle
- init_done  out  1  array sweep complete
- arr_r_en, arr_raddr  out  1, ADDR_W  array read port
- arr_dout  in  DATA_W  array read data, valid the cycle after arr_r_en
- arr_w_en, arr_waddr, arr_din  out  1, ADDR_W, DATA_W  array write port

## Operation
- FSM states: INIT, RUN. Reset -> INIT.
- INIT: counter sweeps 0..2**ADDR_W-1, one write per cycle: arr_w_en=1, arr_waddr=counter, arr_din=0. All rd_req_ready and wr_req_ready low. After writing the last address -> RUN; counter wrap is the transition condition, not an overflow.
- RUN: wr_req_ready=1. A write handshake drives arr_w_en/arr_waddr/arr_din combinationally from the wr_req_* inputs.
- Read arbitration in RUN:
  - Round-robin over rd_req_valid, starting at pointer rr_ptr.
  - At most one grant per cycle. rd_req_ready[i] = RUN and grant[i]. The grant does not depend on ready.
  - On a grant: arr_r_en=1, arr_raddr=granted address, and rr_ptr <= (granted index + 1) mod N_RD. With no grant, rr_ptr holds.
- Response: one cycle after a read handshake, rd_rsp_valid[owner]=1 for exactly one cycle. rd_rsp_data = arr_dout, unless bypass applies. There is no response backpressure.
- Bypass: if a read and a write handshake occur in the same cycle to the same address, register the write data. The next-cycle response returns that write data instead of arr_dout, because the array is read-first.
- rd_rsp_data holds its last value when rd_rsp_valid is all zero. Its content then is don't-care for checking.
- Reset asserted mid-operation clears the FSM to INIT, counter, rr_ptr, and the response pipeline. An in-flight response is dropped. The sweep restarts from address 0.

## Timing
- Reset values:
  - rd_req_ready=0, wr_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, init_done=0
  - arr_r_en=0, arr_w_en=0, arr_raddr=0, arr_waddr=0, arr_din=0
  - rr_ptr=0, counter=0
- INIT lasts exactly 2**ADDR_W cycles after reset release (256 at default).
- init_done goes high in the first RUN cycle and stays high until reset.
- Read latency: request handshake at edge N -> rd_rsp_valid at edge N+1.
- Sustained throughput is one read plus one write per cycle. Back-to-back reads from different requesters produce back-to-back responses.
- A write at edge N is visible to a read handshaken at edge N+1 or later, through the array itself. A read at edge N sees it only through the bypass.

## Structure
- CORE_PKG additions:
  - CACHE_ADDR_W=8 and CACHE_DATA_W=19
  - typedef enum logic {ARB_INIT, ARB_RUN} cache_arb_state_t
- Sub-module rr_arbiter, parameterized by N_RD:
  - inputs req and ptr; output one-hot grant
  - purely combinational
- The rr_ptr register and the response-owner register stay in cache_port_arbiter.

## Test plan
- Init sweep: release rst_n with all requests low -> arr_w_en high for 256 consecutive cycles, arr_waddr 0..255, arr_din=0. init_done rises on cycle 257. Then read address 0x05 -> rd_rsp_data=0.
- Pipelined write/read:
  - Stimulus: write 0x01..0x04 with data 1..4 on consecutive cycles. Requester 0 reads 0x01..0x04 starting one cycle behind.
  - Required response: rd_rsp_valid[0] on four consecutive cycles with data 1,2,3,4.
- Same-cycle collision: write 0x10 <- 19'h7FFFF while requester 1 reads 0x10 in the same cycle -> next-cycle rd_rsp_valid[1] with data 19'h7FFFF.
- Round-robin fairness:
  - Stimulus: both requesters hold valid for 4 cycles, reading 0x01 and 0x02.
  - Required response: grants alternate 0,1,0,1 and responses alternate 0x01 data, 0x02 data, with each rd_rsp_valid one-hot.
- Readiness during INIT: assert rd_req_valid and wr_req_valid during the sweep -> all ready low, no rd_rsp_valid, no stray array writes beyond the sweep pattern.
- Reset mid-operation:
  - Stimulus: drop rst_n the cycle after a read handshake.
  - Required response: rd_rsp_valid stays 0, state returns to INIT, and on release the sweep restarts at address 0 with init_done=0.
